memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Takes the ALU result as the effective address and rs2 as store data, and performs byte/half/word loads and stores over a request/ready data-memory port.
- Stalls upstream while an access is outstanding, then presents a registered result to writeback.
- Detects misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT, 16: maximum cycles in REQ before a bus fault; 0 disables the timeout.
- XLEN, 32: data/address width. Only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  execute stage presents an instruction this cycle.
- in_MemRead  in  1  instruction is a load.
- in_MemWrite  in  1  instruction is a store.
- in_RegWrite  in  1  instruction writes the register file.
- in_RegDest  in  5  destination register.
- in_MemToReg  in  1  writeback selects memory data.
- in_funct3  in  3  access size/sign.
- alu_result  in  32  effective address, or the ALU value for non-memory instructions.
- rs2_value  in  32  store data.
- stop_behind  out  1  upstream must hold its outputs.
- mem_req  out  1  memory request.
- mem_we  out  1  write request.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables.
- mem_rdata  in  32  read data.
- mem_ready  in  1  access complete.
- out_valid  out  1  result valid for writeback.
- out_RegWrite  out  1  register write enable.
- out_RegDest  out  5  destination register.
- out_MemToReg  out  1  writeback mux select.
- out_alu_result  out  32  passed-through ALU value.
- out_mem_data  out  32  formatted load data.
- out_fault  out  1  misaligned, illegal or timeout.

Behaviour:
- Reset: state=IDLE, counter=0, and all out_* are 0. mem_req is decoded from state, so it is 0 the cycle after the reset edge. Reset during REQ abandons the access with no writeback.
- IDLE, posedge with in_valid=1: capture all inputs.
  - Non-memory op: next cycle out_valid=1 with the captured fields. Latency is 1.
  - Memory op, aligned, legal funct3: go to REQ and clear the counter.
  - Misaligned or illegal: next cycle out_valid=1, out_fault=1, out_RegWrite=0, no mem_req.
- IDLE with in_valid=0: out_valid=0 next cycle.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: half-word with addr[0]=1; word with addr[1:0]!=0.
- REQ state:
  - Outputs: mem_req=1, mem_we=captured MemWrite, stop_behind=1. in_valid is ignored.
  - mem_ready=1 at posedge: go to IDLE; next cycle out_valid=1 and out_mem_data=formatted rdata (stores: 0).
  - mem_ready=0: increment the counter. If TIMEOUT!=0 and the counter reaches TIMEOUT-1, go to IDLE with out_valid=1, out_fault=1, out_RegWrite=0.
  - mem_ready in IDLE is ignored.
- stop_behind is 0 in IDLE, so a new instruction is accepted on every IDLE cycle.
- Store formatting:
  - SB: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - SW: wstrb=4'b1111.
- Load formatting: select the lane by addr[1:0]. Sign-extend LB/LH; zero-extend LBU/LHU.
- out_RegWrite is forced to 0 when RegDest==0.

Decomposition:
- cpu_pkg holds the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), the state encoding (IDLE, REQ) and a localparam for the lane count.
- One combinational sub-module, mem_lane_align, produces wdata/wstrb from (funct3, addr[1:0], rs2) and load data from (funct3, addr[1:0], rdata), plus the misaligned/illegal flags.
- The FSM, timeout counter and output registers stay in memory_stage.

Test Plan:
- LW addr 0x100, mem_rdata=0xDEADBEEF, mem_ready on the 3rd REQ cycle -> stop_behind high for 3 cycles; out_mem_data=0xDEADBEEF, out_valid pulse 1 cycle.
- LB addr 0x103, rdata=0x80FFFFFF -> 0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x206, rs2=0x1234ABCD -> mem_wdata=0xABCDABCD, mem_wstrb=4'b1100, mem_we=1.
- LW addr 0x102 -> no mem_req; out_fault=1, out_RegWrite=0, out_valid after 1 cycle.
- ADD result 0x55 with RegDest=5 on back-to-back cycles -> out_valid on consecutive cycles, out_alu_result=0x55, stop_behind=0 throughout. Same with RegDest=0 -> out_RegWrite=0.
- TIMEOUT=4, mem_ready held low -> mem_req high 4 cycles, then out_fault=1. Separately, rst in 2nd REQ cycle -> mem_req=0 next cycle, out_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: funct3 access codes, memory-stage FSM states, lane count and the captured/writeback record types
package cpu_pkg;
  localparam int LANES = 4;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic {IDLE, REQ} state_e;
  typedef struct packed {
    logic        we;
    logic        regwrite;
    logic [4:0]  regdest;
    logic        memtoreg;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] rs2;
  } req_t;
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [4:0]  regdest;
    logic        memtoreg;
    logic [31:0] alu;
    logic [31:0] mem_data;
    logic        fault;
  } wb_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering (funct3/addr/store in; wdata/wstrb/load data/misaligned/illegal out)
module mem_lane_align
  import cpu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic        store_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        illegal_o
);
  logic [31:0] lane;
  assign lane = rdata_i >> {addr_i, 3'b000};
  assign rdata_o = funct3_i == F3_B  ? {{24{lane[7]}}, lane[7:0]} :
                   funct3_i == F3_H  ? {{16{lane[15]}}, lane[15:0]} :
                   funct3_i == F3_BU ? {24'd0, lane[7:0]} :
                   funct3_i == F3_HU ? {16'd0, lane[15:0]} : rdata_i;
  assign wdata_o = funct3_i == F3_B ? {LANES{rs2_i[7:0]}} :
                   funct3_i == F3_H ? {2{rs2_i[15:0]}} : rs2_i;
  assign wstrb_o = (funct3_i == F3_B ? 4'b0001 : funct3_i == F3_H ? 4'b0011 : 4'b1111) << addr_i;
  assign illegal_o = store_i ? !(funct3_i inside {F3_B, F3_H, F3_W})
                             : !(funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign misaligned_o = (funct3_i[1:0] == 2'b01 && addr_i[0]) || (funct3_i[1:0] == 2'b10 && addr_i != 2'b00);
endmodule

// File: rtl/memory_stage.sv
// memory_stage: load/store stage (execute inputs + stop_behind, dmem req/ready port, registered writeback outputs + fault)
module memory_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_MemRead,
  input  logic            in_MemWrite,
  input  logic            in_RegWrite,
  input  logic [4:0]      in_RegDest,
  input  logic            in_MemToReg,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rs2_value,
  output logic            stop_behind,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            out_valid,
  output logic            out_RegWrite,
  output logic [4:0]      out_RegDest,
  output logic            out_MemToReg,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_mem_data,
  output logic            out_fault
);
  state_e state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  req_t cap_q, cap_d;
  wb_t wb_q, wb_d;
  logic in_req, bad, misaligned, illegal;
  logic [31:0] wdata, rdata_fmt;
  logic [3:0] wstrb;
  assign in_req = state_q == REQ;
  // The aligner checks the incoming instruction in IDLE and steers the captured access in REQ.
  mem_lane_align u_align (
    .funct3_i    (in_req ? cap_q.funct3 : in_funct3),
    .addr_i      (in_req ? cap_q.addr[1:0] : alu_result[1:0]),
    .store_i     (in_req ? cap_q.we : in_MemWrite),
    .rs2_i       (cap_q.rs2),
    .rdata_i     (mem_rdata),
    .wdata_o     (wdata),
    .wstrb_o     (wstrb),
    .rdata_o     (rdata_fmt),
    .misaligned_o(misaligned),
    .illegal_o   (illegal)
  );
  assign bad = misaligned || illegal;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cap_d = cap_q;
    wb_d = '0;
    if (!in_req) begin
      if (in_valid) begin
        cap_d = '{we: in_MemWrite, regwrite: in_RegWrite, regdest: in_RegDest, memtoreg: in_MemToReg,
                  funct3: in_funct3, addr: alu_result, rs2: rs2_value};
        wb_d.valid = !(in_MemRead || in_MemWrite) || bad;
        wb_d.fault = (in_MemRead || in_MemWrite) && bad;
        wb_d.regwrite = !(in_MemRead || in_MemWrite) && in_RegWrite && in_RegDest != 5'd0;
        wb_d.regdest = in_RegDest;
        wb_d.memtoreg = in_MemToReg;
        wb_d.alu = alu_result;
        state_d = (in_MemRead || in_MemWrite) && !bad ? REQ : IDLE;
        cnt_d = '0;
      end
    end else if (mem_ready) begin
      state_d = IDLE;
      wb_d.valid = 1'b1;
      wb_d.regwrite = cap_q.regwrite && cap_q.regdest != 5'd0;
      wb_d.regdest = cap_q.regdest;
      wb_d.memtoreg = cap_q.memtoreg;
      wb_d.alu = cap_q.addr;
      wb_d.mem_data = cap_q.we ? 32'd0 : rdata_fmt;
    end else begin
      cnt_d = cnt_q + 32'd1;
      // The counter holds the number of unanswered REQ cycles already elapsed.
      if (TIMEOUT != 0 && cnt_q == 32'(TIMEOUT - 1)) begin
        state_d = IDLE;
        wb_d.valid = 1'b1;
        wb_d.fault = 1'b1;
        wb_d.regdest = cap_q.regdest;
        wb_d.memtoreg = cap_q.memtoreg;
        wb_d.alu = cap_q.addr;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cap_q <= '0;
      wb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cap_q <= cap_d;
      wb_q <= wb_d;
    end
  end
  assign mem_req = in_req;
  assign stop_behind = in_req;
  assign mem_we = in_req && cap_q.we;
  assign mem_addr = {cap_q.addr[31:2], 2'b00};
  assign mem_wdata = mem_we ? wdata : '0;
  assign mem_wstrb = mem_we ? wstrb : '0;
  assign out_valid = wb_q.valid;
  assign out_RegWrite = wb_q.regwrite;
  assign out_RegDest = wb_q.regdest;
  assign out_MemToReg = wb_q.memtoreg;
  assign out_alu_result = wb_q.alu;
  assign out_mem_data = wb_q.mem_data;
  assign out_fault = wb_q.fault;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for memory_stage
module tb_memory_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 0, in_MemRead = 0, in_MemWrite = 0, in_RegWrite = 0, in_MemToReg = 0;
  logic [4:0] in_RegDest = 0;
  logic [2:0] in_funct3 = 0;
  logic [31:0] alu_result = 0, rs2_value = 0, mem_rdata = 0;
  logic mem_ready = 0;
  logic stop_behind, mem_req, mem_we, out_valid, out_RegWrite, out_MemToReg, out_fault;
  logic [31:0] mem_addr, mem_wdata, out_alu_result, out_mem_data;
  logic [3:0] mem_wstrb;
  logic [4:0] out_RegDest;
  int checks = 0, errors = 0, n;

  memory_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
    .in_RegWrite(in_RegWrite), .in_RegDest(in_RegDest), .in_MemToReg(in_MemToReg), .in_funct3(in_funct3),
    .alu_result(alu_result), .rs2_value(rs2_value), .stop_behind(stop_behind), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .out_valid(out_valid), .out_RegWrite(out_RegWrite),
    .out_RegDest(out_RegDest), .out_MemToReg(out_MemToReg), .out_alu_result(out_alu_result),
    .out_mem_data(out_mem_data), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic rw, input logic [4:0] dest,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2);
    in_valid = 1; in_MemRead = rd; in_MemWrite = wr; in_RegWrite = rw; in_RegDest = dest;
    in_MemToReg = rd; in_funct3 = f3; alu_result = addr; rs2_value = rs2;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic serve(input int stall, input logic [31:0] rdata, output int busy);
    busy = 0;
    mem_rdata = rdata;
    for (int i = 0; i < stall; i++) begin
      mem_ready = 0;
      if (stop_behind) busy++;
      @(negedge clk);
    end
    mem_ready = 1;
    if (stop_behind) busy++;
    @(negedge clk);
    mem_ready = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_stop", stop_behind, 0);
    chk("rst_fault", out_fault, 0);
    rst = 0;
    issue(1, 0, 1, 5'd3, 3'b010, 32'h100, 0);
    chk("lw_req", mem_req, 1);
    chk("lw_we", mem_we, 0);
    chk("lw_addr", mem_addr, 32'h100);
    serve(2, 32'hDEADBEEF, n);
    chk("lw_stop_cycles", n, 3);
    chk("lw_valid", out_valid, 1);
    chk("lw_data", out_mem_data, 32'hDEADBEEF);
    chk("lw_regwrite", out_RegWrite, 1);
    chk("lw_dest", out_RegDest, 3);
    chk("lw_stop_after", stop_behind, 0);
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    chk("lw_valid_pulse", out_valid, 0);
    issue(1, 0, 1, 5'd4, 3'b000, 32'h103, 0);
    serve(0, 32'h80FFFFFF, n);
    chk("lb_data", out_mem_data, 32'hFFFFFF80);
    issue(1, 0, 1, 5'd4, 3'b100, 32'h103, 0);
    serve(1, 32'h80FFFFFF, n);
    chk("lbu_data", out_mem_data, 32'h00000080);
    issue(1, 0, 1, 5'd6, 3'b001, 32'h102, 0);
    serve(0, 32'h8001_1234, n);
    chk("lh_data", out_mem_data, 32'hFFFF8001);
    issue(1, 0, 1, 5'd6, 3'b101, 32'h102, 0);
    serve(0, 32'h8001_1234, n);
    chk("lhu_data", out_mem_data, 32'h00008001);
    issue(0, 1, 0, 5'd0, 3'b001, 32'h206, 32'h1234ABCD);
    chk("sh_we", mem_we, 1);
    chk("sh_wdata", mem_wdata, 32'hABCDABCD);
    chk("sh_wstrb", mem_wstrb, 4'b1100);
    chk("sh_addr", mem_addr, 32'h204);
    serve(0, 32'hFFFFFFFF, n);
    chk("sh_valid", out_valid, 1);
    chk("sh_data", out_mem_data, 0);
    issue(0, 1, 0, 5'd0, 3'b000, 32'h301, 32'h000000A5);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("sb_wstrb", mem_wstrb, 4'b0010);
    serve(0, 0, n);
    issue(1, 0, 1, 5'd7, 3'b010, 32'h102, 0);
    chk("mis_req", mem_req, 0);
    chk("mis_valid", out_valid, 1);
    chk("mis_fault", out_fault, 1);
    chk("mis_regwrite", out_RegWrite, 0);
    issue(1, 0, 1, 5'd7, 3'b011, 32'h100, 0);
    chk("ill_load_fault", out_fault, 1);
    chk("ill_load_req", mem_req, 0);
    issue(0, 1, 0, 5'd0, 3'b100, 32'h100, 0);
    chk("ill_store_fault", out_fault, 1);
    issue(0, 0, 1, 5'd5, 3'b000, 32'h55, 0);
    chk("add1_valid", out_valid, 1);
    chk("add1_alu", out_alu_result, 32'h55);
    chk("add1_regwrite", out_RegWrite, 1);
    chk("add1_stop", stop_behind, 0);
    issue(0, 0, 1, 5'd0, 3'b000, 32'h55, 0);
    chk("add2_valid", out_valid, 1);
    chk("add2_regwrite", out_RegWrite, 0);
    chk("add2_fault", out_fault, 0);
    chk("add2_stop", stop_behind, 0);
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    chk("idle_ready_ignored", out_valid, 0);
    issue(1, 0, 1, 5'd9, 3'b010, 32'h300, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!mem_req) break;
      n++;
      @(negedge clk);
    end
    chk("to_req_cycles", n, 4);
    chk("to_valid", out_valid, 1);
    chk("to_fault", out_fault, 1);
    chk("to_regwrite", out_RegWrite, 0);
    issue(1, 0, 1, 5'd9, 3'b010, 32'h400, 0);
    @(negedge clk);
    chk("rstreq_req", mem_req, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstreq_req_after", mem_req, 0);
    chk("rstreq_valid", out_valid, 0);
    mem_ready = 1;
    @(negedge clk);
    mem_ready = 0;
    chk("rstreq_no_wb", out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
